// File: rtl/fetch_insn_queue.sv
// Fetch-to-predecode instruction queue: compacting multi-slot enqueue, FWFT multi-slot dequeue.
// Optional enqueue-stall counter enabled by defining FETCH_INSN_QUEUE_STALL_COUNTER_EN.
module fetch_insn_queue #(
  parameter int unsigned FETCH_WIDTH  = 2,
  parameter int unsigned DECODE_WIDTH = 2,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned INSN_W       = 32,
  parameter int unsigned PC_W         = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush,
  input  logic [FETCH_WIDTH-1:0]               enq_valid,
  input  logic [FETCH_WIDTH*INSN_W-1:0]        enq_insn,
  input  logic [FETCH_WIDTH*PC_W-1:0]          enq_pc,
  input  logic [FETCH_WIDTH-1:0]               enq_br_taken,
  output logic                                 enq_ready,
  output logic [DECODE_WIDTH-1:0]              deq_valid,
  output logic [DECODE_WIDTH*INSN_W-1:0]       deq_insn,
  output logic [DECODE_WIDTH*PC_W-1:0]         deq_pc,
  output logic [DECODE_WIDTH-1:0]              deq_br_taken,
  input  logic [$clog2(DECODE_WIDTH+1)-1:0]    deq_count,
  output logic [$clog2(DEPTH+1)-1:0]           occupancy,
  output logic [31:0]                          stall_cycles
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH+1);

  logic [INSN_W-1:0] insnMem [DEPTH];
  logic [PC_W-1:0]   pcMem   [DEPTH];
  logic [DEPTH-1:0]  brMem;

  logic [PtrW-1:0] headQ, headD, tailQ, tailD;
  logic [CntW-1:0] countQ, countD;
  logic [CntW-1:0] nEnq, deqEff;
  logic [PtrW-1:0] slotOff;
  logic [PtrW-1:0] wrIdx [FETCH_WIDTH];
  logic            doEnq;

  // Ready depends on registered count only, so no path from deq_count/enq_valid.
  assign enq_ready = (countQ <= CntW'(DEPTH - FETCH_WIDTH));
  assign occupancy = countQ;
  assign doEnq     = enq_ready && (|enq_valid);

  always_comb begin
    nEnq    = '0;
    slotOff = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      wrIdx[i] = tailQ + slotOff;
      if (enq_valid[i]) begin
        slotOff = slotOff + PtrW'(1);
        nEnq    = nEnq + CntW'(1);
      end
    end
    // Over-dequeue is illegal; clamp so state stays consistent anyway.
    deqEff = (CntW'(deq_count) > countQ) ? countQ : CntW'(deq_count);
    headD  = headQ;
    tailD  = tailQ;
    countD = countQ;
    if (flush) begin
      headD  = '0;
      tailD  = '0;
      countD = '0;
    end else begin
      headD  = headQ + deqEff[PtrW-1:0];
      tailD  = doEnq ? tailQ + nEnq[PtrW-1:0] : tailQ;
      countD = countQ + (doEnq ? nEnq : '0) - deqEff;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      headQ  <= '0;
      tailQ  <= '0;
      countQ <= '0;
    end else begin
      headQ  <= headD;
      tailQ  <= tailD;
      countQ <= countD;
    end
  end

  always_ff @(posedge clk) begin
    if (doEnq && !flush) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        if (enq_valid[i]) begin
          insnMem[wrIdx[i]] <= enq_insn[i*INSN_W +: INSN_W];
          pcMem[wrIdx[i]]   <= enq_pc[i*PC_W +: PC_W];
          brMem[wrIdx[i]]   <= enq_br_taken[i];
        end
      end
    end
  end

  always_comb begin
    deq_valid    = '0;
    deq_insn     = '0;
    deq_pc       = '0;
    deq_br_taken = '0;
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      deq_valid[i]                   = CntW'(i) < countQ;
      deq_insn[i*INSN_W +: INSN_W]   = insnMem[headQ + PtrW'(i)];
      deq_pc[i*PC_W +: PC_W]         = pcMem[headQ + PtrW'(i)];
      deq_br_taken[i]                = brMem[headQ + PtrW'(i)];
    end
  end

`ifdef FETCH_INSN_QUEUE_STALL_COUNTER_EN
  logic [31:0] stallQ;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stallQ <= '0;
    end else if ((|enq_valid) && !enq_ready && !flush && (stallQ != '1)) begin
      stallQ <= stallQ + 32'd1;
    end
  end

  assign stall_cycles = stallQ;
`else
  assign stall_cycles = '0;
`endif

  deqCountLegal: assert property (@(posedge clk) disable iff (!rst)
    CntW'(deq_count) <= countQ);

endmodule

// File: tb/tb_fetch_insn_queue.sv
// Directed self-checking bench for fetch_insn_queue (default parameters).
module tb_fetch_insn_queue;

  localparam logic [31:0] InsnKey = 32'hA5A5_0000;
`ifdef FETCH_INSN_QUEUE_STALL_COUNTER_EN
  localparam logic [31:0] StallExp = 32'd1;
`else
  localparam logic [31:0] StallExp = 32'd0;
`endif

  logic        clk;
  logic        rst;
  logic        flush;
  logic [1:0]  enq_valid;
  logic [63:0] enq_insn;
  logic [63:0] enq_pc;
  logic [1:0]  enq_br_taken;
  logic        enq_ready;
  logic [1:0]  deq_valid;
  logic [63:0] deq_insn;
  logic [63:0] deq_pc;
  logic [1:0]  deq_br_taken;
  logic [1:0]  deq_count;
  logic [3:0]  occupancy;
  logic [31:0] stall_cycles;

  int nCmp;
  int nFail;

  fetch_insn_queue dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .enq_valid    (enq_valid),
    .enq_insn     (enq_insn),
    .enq_pc       (enq_pc),
    .enq_br_taken (enq_br_taken),
    .enq_ready    (enq_ready),
    .deq_valid    (deq_valid),
    .deq_insn     (deq_insn),
    .deq_pc       (deq_pc),
    .deq_br_taken (deq_br_taken),
    .deq_count    (deq_count),
    .occupancy    (occupancy),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1,
                       input logic [1:0] br, input logic [1:0] dc);
    enq_valid    = v;
    enq_pc       = {pc1, pc0};
    enq_insn     = {pc1 ^ InsnKey, pc0 ^ InsnKey};
    enq_br_taken = br;
    deq_count    = dc;
  endtask

  initial begin
    logic [31:0] nextPc;
    logic [31:0] headPc;
    nCmp  = 0;
    nFail = 0;
    rst   = 1'b0;
    flush = 1'b0;
    drive(2'b00, 32'h0, 32'h0, 2'b00, 2'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    tick();

    // Reset / idle state
    check("rst_enq_ready", enq_ready, 1);
    check("rst_deq_valid", deq_valid, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_stall", stall_cycles, 0);

    // Full group enqueue, visible one cycle later
    drive(2'b11, 32'h1000, 32'h1004, 2'b10, 2'd0);
    tick();
    drive(2'b00, 32'h0, 32'h0, 2'b00, 2'd0);
    check("enq2_deq_valid", deq_valid, 2'b11);
    check("enq2_deq_pc", deq_pc, {32'h1004, 32'h1000});
    check("enq2_deq_insn", deq_insn, {32'h1004 ^ InsnKey, 32'h1000 ^ InsnKey});
    check("enq2_br", deq_br_taken, 2'b10);
    check("enq2_occ", occupancy, 2);
    deq_count = 2'd2;
    tick();
    deq_count = 2'd0;
    check("deq2_occ", occupancy, 0);
    check("deq2_valid", deq_valid, 0);

    // Hole compaction
    drive(2'b10, 32'h2000, 32'h2004, 2'b00, 2'd0);
    tick();
    drive(2'b00, 32'h0, 32'h0, 2'b00, 2'd0);
    check("hole_deq_valid", deq_valid, 2'b01);
    check("hole_deq_pc0", deq_pc[31:0], 32'h2004);
    check("hole_occ", occupancy, 1);
    deq_count = 2'd1;
    tick();
    deq_count = 2'd0;
    check("hole_drain_occ", occupancy, 0);

    // Fill to full with no dequeue
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, 32'h3000 + 32'(8*k), 32'h3004 + 32'(8*k), 2'b00, 2'd0);
      tick();
      if (k == 2) begin
        check("fill3_occ", occupancy, 6);
        check("fill3_ready", enq_ready, 1);
      end
    end
    check("full_occ", occupancy, 8);
    check("full_ready", enq_ready, 0);
    check("full_deq_valid", deq_valid, 2'b11);
    drive(2'b11, 32'h9000, 32'h9004, 2'b00, 2'd0);
    tick();
    drive(2'b00, 32'h0, 32'h0, 2'b00, 2'd0);
    check("ignored_occ", occupancy, 8);
    check("stall_count", stall_cycles, StallExp);

    // Drain in order; the ignored group must never appear
    for (int j = 0; j < 4; j++) begin
      check("drain_pc0", deq_pc[31:0], 32'h3000 + 32'(8*j));
      check("drain_pc1", deq_pc[63:32], 32'h3004 + 32'(8*j));
      deq_count = 2'd2;
      tick();
    end
    deq_count = 2'd0;
    check("drain_occ", occupancy, 0);

    // Bring tail to 7 (head=tail=3 now), then steady enqueue+dequeue across the wrap
    nextPc = 32'h4000;
    headPc = 32'h4000;
    for (int k = 0; k < 2; k++) begin
      drive(2'b11, nextPc, nextPc + 32'd4, 2'b00, 2'd0);
      tick();
      nextPc = nextPc + 32'd8;
    end
    check("wrap_pre_occ", occupancy, 4);
    for (int k = 0; k < 10; k++) begin
      drive(2'b11, nextPc, nextPc + 32'd4, 2'b00, 2'd2);
      check("wrap_pc0", deq_pc[31:0], headPc);
      check("wrap_pc1", deq_pc[63:32], headPc + 32'd4);
      tick();
      nextPc = nextPc + 32'd8;
      headPc = headPc + 32'd8;
      check("wrap_occ", occupancy, 4);
    end

    // Flush from occupancy 5 with concurrent enqueue and dequeue
    drive(2'b01, 32'h6000, 32'h0, 2'b00, 2'd0);
    tick();
    check("preflush_occ", occupancy, 5);
    drive(2'b11, 32'h6100, 32'h6104, 2'b00, 2'd2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(2'b00, 32'h0, 32'h0, 2'b00, 2'd0);
    check("flush_occ", occupancy, 0);
    check("flush_deq_valid", deq_valid, 0);
    check("flush_ready", enq_ready, 1);
    check("flush_stall", stall_cycles, StallExp);

    // Asynchronous reset mid-cycle
    drive(2'b11, 32'h7000, 32'h7004, 2'b00, 2'd0);
    tick();
    drive(2'b11, 32'h7008, 32'h700C, 2'b00, 2'd0);
    tick();
    drive(2'b00, 32'h0, 32'h0, 2'b00, 2'd0);
    check("prerst_occ", occupancy, 4);
    #2 rst = 1'b0;
    #1;
    check("arst_deq_valid", deq_valid, 0);
    check("arst_occ", occupancy, 0);
    check("arst_ready", enq_ready, 1);
    check("arst_stall", stall_cycles, 0);
    #2 rst = 1'b1;
    tick();
    drive(2'b11, 32'h5000, 32'h5004, 2'b00, 2'd0);
    tick();
    drive(2'b00, 32'h0, 32'h0, 2'b00, 2'd0);
    check("postrst_valid", deq_valid, 2'b11);
    check("postrst_pc", deq_pc, {32'h5004, 32'h5000});
    check("postrst_occ", occupancy, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
